// File: rtl/unsat_clause_buffer.sv
// Dense set of unsatisfied clause IDs held in slots 0..count-1 so a random
// slot index maps straight to a clause. A per-clause position map (valid bit
// plus slot) rejects duplicate inserts and locates entries for removal; a
// removal fills its hole by moving the last slot into it.
//
// Handshake: a request is accepted on a rising edge where op_valid_i and
// op_ready_o are both high. op_ready_o stays low until the accepted op has
// completed. Read results appear as a one-cycle rd_valid_o pulse.
module unsat_clause_buffer #(
    parameter int BUFFER_DEPTH = 2048,
    parameter int NUM_CLAUSES  = 4096,
    parameter int CW           = $clog2(NUM_CLAUSES),
    parameter int AW           = $clog2(BUFFER_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid_i,
    output logic          op_ready_o,
    input  logic [1:0]    op_i,
    input  logic [CW-1:0] clause_i,
    input  logic [AW-1:0] index_i,
    output logic          rd_valid_o,
    output logic [CW-1:0] rd_clause_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          err_o,
    output logic [3:0]    dbg_state_o
);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IDLE     = 4'd1,
        S_INS_LOOK = 4'd2,
        S_INS_WR   = 4'd3,
        S_REM_LOOK = 4'd4,
        S_REM_LAST = 4'd5,
        S_REM_MOVE = 4'd6,
        S_REM_CLR  = 4'd7,
        S_RD       = 4'd8,
        S_RD_OUT   = 4'd9
    } state_t;

    localparam logic [1:0]    OP_INSERT = 2'b01;
    localparam logic [1:0]    OP_REMOVE = 2'b10;
    localparam logic [1:0]    OP_READ   = 2'b11;
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(BUFFER_DEPTH);
    localparam logic [AW-1:0] SLOT_ONE  = AW'(1);
    localparam logic [CW-1:0] LAST_ID   = CW'(NUM_CLAUSES - 1);

    // Storage: slot -> clause, and clause -> {valid, slot}
    logic [CW-1:0] r_buf_mem [BUFFER_DEPTH];
    logic [AW:0]   r_pos_map [NUM_CLAUSES];
    logic [CW-1:0] r_buf_rdata;
    logic [AW:0]   r_pm_rdata;

    state_t        r_state;
    logic [CW-1:0] r_init_addr;
    logic          r_ready;
    logic [AW:0]   r_count;
    logic          r_rd_valid;
    logic [CW-1:0] r_rd_clause;
    logic          r_err;
    logic [CW-1:0] r_clause;
    logic [AW-1:0] r_index;
    logic [AW-1:0] r_slot;

    logic          w_full;
    logic          w_ins_ok;
    logic          w_idx_ok;
    logic          w_pm_we;
    logic [CW-1:0] w_pm_waddr;
    logic [AW:0]   w_pm_wdata;
    logic          w_buf_we;
    logic [AW-1:0] w_buf_waddr;
    logic [CW-1:0] w_buf_wdata;
    logic [AW-1:0] w_buf_raddr;

    assign w_full   = (r_count == CNT_FULL);
    assign w_ins_ok = !r_pm_rdata[AW] && !w_full;
    assign w_idx_ok = ({1'b0, r_index} < r_count);

    // Memory port steering: one write port per memory, plus the buffer read address.
    // The buffer is read with index_i on every idle cycle so a read's data is
    // already registered by the time the FSM reaches S_RD.
    always_comb begin
        w_pm_we     = 1'b0;
        w_pm_waddr  = r_clause;
        w_pm_wdata  = '0;
        w_buf_we    = 1'b0;
        w_buf_waddr = r_count[AW-1:0];
        w_buf_wdata = r_clause;
        w_buf_raddr = index_i;
        if (!reset) begin
            case (r_state)
                S_INIT: begin
                    w_pm_we    = 1'b1;
                    w_pm_waddr = r_init_addr;
                    w_pm_wdata = '0;
                end
                S_INS_WR: begin
                    if (w_ins_ok) begin
                        w_pm_we    = 1'b1;
                        w_pm_wdata = {1'b1, r_count[AW-1:0]};
                        w_buf_we   = 1'b1;
                    end
                end
                S_REM_LAST: begin
                    w_buf_raddr = r_count[AW-1:0] - SLOT_ONE;
                end
                S_REM_MOVE: begin
                    w_buf_we    = 1'b1;
                    w_buf_waddr = r_slot;
                    w_buf_wdata = r_buf_rdata;
                    w_pm_we     = 1'b1;
                    w_pm_waddr  = r_buf_rdata;
                    w_pm_wdata  = {1'b1, r_slot};
                end
                S_REM_CLR: begin
                    // Runs after the move so removing the last slot still ends invalid.
                    w_pm_we    = 1'b1;
                    w_pm_waddr = r_clause;
                    w_pm_wdata = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Slot buffer: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf_mem[w_buf_waddr] <= w_buf_wdata;
        end
        r_buf_rdata <= r_buf_mem[w_buf_raddr];
    end

    // Position map: one write port, registered read of the latched clause
    always_ff @(posedge clk) begin
        if (w_pm_we) begin
            r_pos_map[w_pm_waddr] <= w_pm_wdata;
        end
        r_pm_rdata <= r_pos_map[r_clause];
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_init_addr <= '0;
            r_ready     <= 1'b0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_clause <= '0;
            r_err       <= 1'b0;
            r_clause    <= '0;
            r_index     <= '0;
            r_slot      <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_init_addr <= r_init_addr + CW'(1);
                    if (r_init_addr == LAST_ID) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE, S_RD_OUT: begin
                    r_state <= S_IDLE;
                    if (op_valid_i && r_ready) begin
                        r_clause <= clause_i;
                        r_index  <= index_i;
                        case (op_i)
                            OP_INSERT: begin
                                r_state <= S_INS_LOOK;
                                r_ready <= 1'b0;
                            end
                            OP_REMOVE: begin
                                r_state <= S_REM_LOOK;
                                r_ready <= 1'b0;
                            end
                            OP_READ: begin
                                r_state <= S_RD;
                                r_ready <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_INS_LOOK: begin
                    r_state <= S_INS_WR;
                end
                S_INS_WR: begin
                    if (w_ins_ok) begin
                        r_count <= r_count + CNT_ONE;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_REM_LOOK: begin
                    r_state <= S_REM_LAST;
                end
                S_REM_LAST: begin
                    if (!r_pm_rdata[AW]) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_slot  <= r_pm_rdata[AW-1:0];
                        r_state <= S_REM_MOVE;
                    end
                end
                S_REM_MOVE: begin
                    r_state <= S_REM_CLR;
                end
                S_REM_CLR: begin
                    r_count <= r_count - CNT_ONE;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_RD: begin
                    r_rd_valid  <= 1'b1;
                    r_rd_clause <= w_idx_ok ? r_buf_rdata : '0;
                    if (!w_idx_ok) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_RD_OUT;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready_o  = r_ready;
    assign rd_valid_o  = r_rd_valid;
    assign rd_clause_o = r_rd_clause;
    assign count_o     = r_count;
    assign empty_o     = (r_count == '0);
    assign full_o      = w_full;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_unsat_clause_buffer.sv
// Directed and randomized checks of unsat_clause_buffer against a queue model
// of the clause set: insert appends, remove overwrites the hole with the last
// entry and drops the tail, read returns the entry at an index.
module tb_unsat_clause_buffer;

    localparam int D  = 2048;
    localparam int N  = 4096;
    localparam int CW = $clog2(N);
    localparam int AW = $clog2(D);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_INS = 2'b01;
    localparam logic [1:0] OP_REM = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    logic          clk;
    logic          reset;
    logic          op_valid_i;
    logic          op_ready_o;
    logic [1:0]    op_i;
    logic [CW-1:0] clause_i;
    logic [AW-1:0] index_i;
    logic          rd_valid_o;
    logic [CW-1:0] rd_clause_o;
    logic [AW:0]   count_o;
    logic          empty_o;
    logic          full_o;
    logic          err_o;
    logic [3:0]    dbg_state_o;

    int errors = 0;
    int checks = 0;

    // Reference model: ordered contents and sticky error
    logic [CW-1:0] exp_q[$];
    bit            exp_err;

    unsat_clause_buffer #(
        .BUFFER_DEPTH(D),
        .NUM_CLAUSES (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .op_i       (op_i),
        .clause_i   (clause_i),
        .index_i    (index_i),
        .rd_valid_o (rd_valid_o),
        .rd_clause_o(rd_clause_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .err_o      (err_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int find_id(input int id);
        foreach (exp_q[i]) begin
            if (int'(exp_q[i]) == id) return i;
        end
        return -1;
    endfunction

    task automatic chk_status(input string name);
        chk({name, "_count"}, 32'(count_o), exp_q.size());
        chk({name, "_empty"}, 32'(empty_o), (exp_q.size() == 0) ? 1 : 0);
        chk({name, "_full"},  32'(full_o),  (exp_q.size() == D) ? 1 : 0);
        chk({name, "_err"},   32'(err_o),   32'(exp_err));
    endtask

    // Reset, then time the position-map sweep
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        op_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready",    32'(op_ready_o),  0);
        chk("reset_rd_valid", 32'(rd_valid_o),  0);
        chk("reset_rd_clause", 32'(rd_clause_o), 0);
        reset = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == N - 1) chk("init_ready_early", 32'(op_ready_o), 0);
        end
        chk("init_ready", 32'(op_ready_o), 1);
        chk_status("init");
    endtask

    // Drive one op, update the model, check latency, read data and status
    task automatic run_op(input logic [1:0] op, input int clause, input int idx, input string name);
        int exp_lat;
        int exp_rd;
        int pos;
        int n;
        int rd_cyc;
        logic [CW-1:0] rd_val;
        exp_rd = 0;
        case (op)
            OP_INS: begin
                exp_lat = 3;
                if (find_id(clause) >= 0 || exp_q.size() == D) exp_err = 1'b1;
                else exp_q.push_back(CW'(clause));
            end
            OP_REM: begin
                pos = find_id(clause);
                if (pos < 0) begin
                    exp_lat = 3;
                    exp_err = 1'b1;
                end else begin
                    exp_lat = 5;
                    exp_q[pos] = exp_q[exp_q.size() - 1];
                    void'(exp_q.pop_back());
                end
            end
            OP_RD: begin
                exp_lat = 2;
                if (idx < exp_q.size()) exp_rd = int'(exp_q[idx]);
                else exp_err = 1'b1;
            end
            default: exp_lat = 1;
        endcase
        n = 0;
        while (!op_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready_o) begin
            chk({name, "_wait_ready"}, 32'(op_ready_o), 1);
            return;
        end
        op_valid_i = 1'b1;
        op_i       = op;
        clause_i   = CW'(clause);
        index_i    = AW'(idx);
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        op_i       = OP_NOP;
        n      = 1;
        rd_cyc = 0;
        rd_val = '0;
        if (rd_valid_o) begin
            rd_cyc = n;
            rd_val = rd_clause_o;
        end
        while (!op_ready_o && n < 20) begin
            @(negedge clk);
            n++;
            if (rd_valid_o && rd_cyc == 0) begin
                rd_cyc = n;
                rd_val = rd_clause_o;
            end
        end
        chk({name, "_latency"}, n, exp_lat);
        if (op == OP_RD) begin
            chk({name, "_rd_cycle"}, rd_cyc, 2);
            chk({name, "_rd_clause"}, 32'(rd_val), exp_rd);
        end else begin
            chk({name, "_no_rd_pulse"}, rd_cyc, 0);
        end
        chk_status(name);
    endtask

    initial begin
        int sel;
        int id;
        reset      = 1'b1;
        op_valid_i = 1'b0;
        op_i       = OP_NOP;
        clause_i   = '0;
        index_i    = '0;
        exp_err    = 1'b0;

        // Basic insert / read / remove-middle / re-insert
        do_reset();
        run_op(OP_INS, 5, 0, "ins5");
        run_op(OP_INS, 9, 0, "ins9");
        run_op(OP_INS, 12, 0, "ins12");
        run_op(OP_RD, 0, 0, "rd0");
        run_op(OP_RD, 0, 1, "rd1");
        run_op(OP_RD, 0, 2, "rd2");
        run_op(OP_REM, 5, 0, "rem5");
        run_op(OP_RD, 0, 0, "rd0_after_rem");
        run_op(OP_RD, 0, 1, "rd1_after_rem");
        run_op(OP_INS, 5, 0, "reins5");
        run_op(OP_RD, 0, 2, "rd2_reins");
        run_op(OP_NOP, 0, 0, "nop");

        // Randomized legal traffic on top of the current contents
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                do id = $urandom_range(0, N - 1); while (find_id(id) >= 0);
                run_op(OP_INS, id, 0, "rnd_ins");
            end else if (sel < 7 && exp_q.size() > 0) begin
                id = int'(exp_q[$urandom_range(0, exp_q.size() - 1)]);
                run_op(OP_REM, id, 0, "rnd_rem");
            end else if (sel < 9 && exp_q.size() > 0) begin
                run_op(OP_RD, 0, $urandom_range(0, exp_q.size() - 1), "rnd_rd");
            end else begin
                run_op(OP_NOP, 0, 0, "rnd_nop");
            end
        end
        for (int i = 0; i < exp_q.size(); i++) run_op(OP_RD, 0, i, "rnd_sweep_rd");

        // Remove the entry in the last slot, then remove it again
        do_reset();
        run_op(OP_INS, 5, 0, "b_ins5");
        run_op(OP_INS, 9, 0, "b_ins9");
        run_op(OP_INS, 12, 0, "b_ins12");
        run_op(OP_REM, 12, 0, "b_rem_last");
        run_op(OP_RD, 0, 1, "b_rd1");
        run_op(OP_REM, 12, 0, "b_rem_again");

        // Duplicate insert
        do_reset();
        run_op(OP_INS, 5, 0, "c_ins5");
        run_op(OP_INS, 9, 0, "c_ins9");
        run_op(OP_INS, 9, 0, "c_ins9_dup");
        run_op(OP_INS, 12, 0, "c_ins12");

        // Read past the end, and remove from an empty set
        do_reset();
        run_op(OP_REM, 3, 0, "d_rem_empty");
        do_reset();
        run_op(OP_INS, 5, 0, "e_ins5");
        run_op(OP_INS, 9, 0, "e_ins9");
        run_op(OP_INS, 12, 0, "e_ins12");
        run_op(OP_RD, 0, 7, "e_rd_oob");

        // Fill, overflow, drain
        do_reset();
        for (int i = 0; i < D; i++) run_op(OP_INS, (i * 3 + 7) % N, 0, "f_fill");
        run_op(OP_RD, 0, D - 1, "f_rd_last");
        run_op(OP_INS, 1, 0, "f_ins_full");
        for (int i = 0; i < D; i++) begin
            run_op(OP_REM, (i * 3 + 7) % N, 0, "f_drain");
            if (i == D / 2) run_op(OP_RD, 0, $urandom_range(0, exp_q.size() - 1), "f_rd_mid");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
